// File: rtl/isqrt_pipe_restoring.sv
// Pipelined integer square root, one root bit per stage (restoring method).
// Valid bits reset; data registers load only when their stage input is valid.
module isqrt_pipe_restoring #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x_vld,
  input  logic [WIDTH-1:0]   x,
  output logic               y_vld,
  output logic [WIDTH/2-1:0] y
);

  localparam int N = WIDTH / 2;

  logic [N-1:0] r_vld;

  always_ff @(posedge clk) begin
    if (rst) r_vld <= '0;
    else     r_vld <= {r_vld[N-2:0], x_vld};
  end

  for (genvar k = 0; k < N; k++) begin : g_stg
    logic [N+1:0]     r_rem;
    logic [N-1:0]     r_root;
    logic [WIDTH-1:0] r_xs;

    logic [N+1:0]     w_rem;
    logic [N-1:0]     w_root;
    logic [WIDTH-1:0] w_xs;
    logic             w_vld;

    if (k == 0) begin : g_in
      assign w_rem  = '0;
      assign w_root = '0;
      assign w_xs   = x;
      assign w_vld  = x_vld;
    end else begin : g_in
      assign w_rem  = g_stg[k-1].r_rem;
      assign w_root = g_stg[k-1].r_root;
      assign w_xs   = g_stg[k-1].r_xs;
      assign w_vld  = r_vld[k-1];
    end

    logic [N+1:0] w_cand;
    logic [N+1:0] w_sub;
    logic [N+1:0] w_trial;
    logic         w_ge;
    logic         w_unused;

    // Remainder never exceeds N bits between stages; top bits drop out.
    assign w_cand   = {w_rem[N-1:0], w_xs[WIDTH-1 -: 2]};
    assign w_sub    = {w_root, 2'b01};
    assign w_ge     = (w_cand >= w_sub);
    assign w_trial  = w_cand - w_sub;
    assign w_unused = ^w_rem[N+1:N];

    always_ff @(posedge clk) begin
      if (w_vld) begin
        r_rem  <= w_ge ? w_trial : w_cand;
        r_root <= {w_root[N-2:0], w_ge};
        r_xs   <= w_xs << 2;
      end
    end
  end

  logic w_unused_tail;
  assign w_unused_tail = ^{g_stg[N-1].r_rem, g_stg[N-1].r_xs};

  assign y_vld = r_vld[N-1];
  assign y     = g_stg[N-1].r_root;

endmodule
